// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl
//
// Purpose: controls a circular trace buffer. After arming, every valid
// sample is written at the write pointer until a trigger arrives; a
// programmable number of post-trigger samples is then captured and the
// block parks in DONE. A readout replays the buffer oldest-first.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   arm, abort          start a capture / return to idle from anywhere
//   trigger             trigger event, honoured only while ARMED
//   sample_valid        a trace sample is present this cycle
//   post_count          post-trigger sample count, latched at the trigger
//   write__ENA/__addr   buffer write strobe and address (addr 0 when idle)
//   write__RDY          buffer accepts a write this cycle
//   read_start          begin readout from DONE
//   read__ENA/__addr    buffer read strobe and address (addr 0 when idle)
//   read__last          marks the final read of a readout
//   read__RDY           downstream accepts a read this cycle
//   state               IDLE=0, ARMED=1, POST=2, DONE=3, READ=4
//   trig_addr           write pointer captured at the trigger
//   wrapped             buffer filled at least once during this capture
//   drops               saturating count of samples lost to write__RDY low

module trace_capture_ctrl #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          arm,
    input  logic          abort,
    input  logic          trigger,
    input  logic          sample_valid,
    input  logic [AW-1:0] post_count,
    output logic          write__ENA,
    output logic [AW-1:0] write__addr,
    input  logic          write__RDY,
    input  logic          read_start,
    output logic          read__ENA,
    output logic [AW-1:0] read__addr,
    output logic          read__last,
    input  logic          read__RDY,
    output logic [2:0]    state,
    output logic [AW-1:0] trig_addr,
    output logic          wrapped,
    output logic [7:0]    drops
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t        state_q,   state_d;
    logic [AW-1:0] wptr_q,    wptr_d;
    logic [AW-1:0] rptr_q,    rptr_d;
    logic [AW-1:0] rem_q,     rem_d;
    logic [AW:0]   cnt_q,     cnt_d;
    logic [AW-1:0] trig_q,    trig_d;
    logic          wrapped_q, wrapped_d;
    logic [7:0]    drops_q,   drops_d;

    logic capturing;
    logic wr_fire;
    logic rd_fire;

    // Strobes are gated by RST so nothing escapes to the buffer while a
    // reset is being applied mid-capture or mid-readout.
    always_comb begin
        capturing = (state_q == S_ARMED) || (state_q == S_POST);
        wr_fire   = !RST && capturing && sample_valid && write__RDY;
        rd_fire   = !RST && (state_q == S_READ) && read__RDY && (cnt_q != '0);
    end

    // Next-state computation. Pointer and counter side effects of a
    // write or read happen first so that an aborted cycle still completes
    // its transfer; abort then overrides every state transition.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        trig_d    = trig_q;
        wrapped_d = wrapped_q;
        drops_d   = drops_q;

        if (wr_fire) begin
            wptr_d = wptr_q + 1'b1;
            if (&wptr_q) begin
                wrapped_d = 1'b1;
            end
        end

        if (capturing && sample_valid && !write__RDY && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end

        if (rd_fire) begin
            rptr_d = rptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d   = S_ARMED;
                        wptr_d    = '0;
                        wrapped_d = 1'b0;
                        drops_d   = '0;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        trig_d  = wptr_q;
                        rem_d   = post_count;
                        state_d = (post_count == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (wr_fire) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == AW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A wrapped buffer starts its oldest entry at wptr.
                    if (arm) begin
                        state_d   = S_ARMED;
                        wptr_d    = '0;
                        wrapped_d = 1'b0;
                        drops_d   = '0;
                    end else if (read_start) begin
                        state_d = S_READ;
                        rptr_d  = wrapped_q ? wptr_q : '0;
                        cnt_d   = wrapped_q ? CNT_FULL : {1'b0, wptr_q};
                    end
                end
                S_READ: begin
                    if ((cnt_q == '0) || (rd_fire && (cnt_q == CNT_ONE))) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Single register bank for the whole controller.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            trig_q    <= '0;
            wrapped_q <= 1'b0;
            drops_q   <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            wrapped_q <= wrapped_d;
            drops_q   <= drops_d;
        end
    end

    assign write__ENA  = wr_fire;
    assign write__addr = wr_fire ? wptr_q : '0;
    assign read__ENA   = rd_fire;
    assign read__addr  = rd_fire ? rptr_q : '0;
    assign read__last  = rd_fire && (cnt_q == CNT_ONE);
    assign state       = state_q;
    assign trig_addr   = trig_q;
    assign wrapped     = wrapped_q;
    assign drops       = drops_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl
//
// Purpose: self-checking bench for trace_capture_ctrl with DEPTH=16.
// Directed scenarios exercise the documented capture/readout cases and a
// randomized run compares every output each cycle against a behavioural
// model that keeps the expected readout as a queue of addresses.

module tb_trace_capture_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_POST  = 2;
    localparam int M_DONE  = 3;
    localparam int M_READ  = 4;

    logic          CLK;
    logic          RST;
    logic          arm;
    logic          abort;
    logic          trigger;
    logic          sample_valid;
    logic [AW-1:0] post_count;
    logic          write_ena;
    logic [AW-1:0] write_addr;
    logic          write_rdy;
    logic          read_start;
    logic          read_ena;
    logic [AW-1:0] read_addr;
    logic          read_last;
    logic          read_rdy;
    logic [2:0]    state_o;
    logic [AW-1:0] trig_addr;
    logic          wrapped;
    logic [7:0]    drops;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int m_state, m_wptr, m_rem, m_trig, m_drops;
    bit m_wrapped;
    int rq[$];

    // Readout capture results.
    int rd_addrs[$];
    int rd_last_idx;
    int rd_last_count;
    int rd_viol;
    bit rd_done;

    trace_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .arm          (arm),
        .abort        (abort),
        .trigger      (trigger),
        .sample_valid (sample_valid),
        .post_count   (post_count),
        .write__ENA   (write_ena),
        .write__addr  (write_addr),
        .write__RDY   (write_rdy),
        .read_start   (read_start),
        .read__ENA    (read_ena),
        .read__addr   (read_addr),
        .read__last   (read_last),
        .read__RDY    (read_rdy),
        .state        (state_o),
        .trig_addr    (trig_addr),
        .wrapped      (wrapped),
        .drops        (drops)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit exp_wen();
        return !RST && (m_state == M_ARMED || m_state == M_POST) && sample_valid && write_rdy;
    endfunction

    function automatic bit exp_ren();
        return !RST && (m_state == M_READ) && read_rdy && (rq.size() > 0);
    endfunction

    // Model advance at a rising edge, from the inputs present at that edge.
    task automatic model_update();
        int old_w;
        int sz;
        bit act;
        bit wen;
        bit ren;
        old_w = m_wptr;
        sz    = rq.size();
        act   = (m_state == M_ARMED) || (m_state == M_POST);
        wen   = act && sample_valid && write_rdy;
        ren   = (m_state == M_READ) && read_rdy && (sz > 0);
        if (RST) begin
            m_state = M_IDLE; m_wptr = 0; m_rem = 0; m_trig = 0;
            m_wrapped = 0; m_drops = 0; rq.delete();
            return;
        end
        if (wen) begin
            if (m_wptr == DEPTH - 1) m_wrapped = 1;
            m_wptr = (m_wptr + 1) % DEPTH;
        end
        if (act && sample_valid && !write_rdy && m_drops < 255) m_drops++;
        if (ren) void'(rq.pop_front());
        if (abort) begin
            m_state = M_IDLE;
            return;
        end
        case (m_state)
            M_IDLE, M_DONE: begin
                if (arm) begin
                    m_state = M_ARMED; m_wptr = 0; m_wrapped = 0; m_drops = 0;
                end else if (m_state == M_DONE && read_start) begin
                    m_state = M_READ;
                    rq.delete();
                    if (m_wrapped) for (int i = 0; i < DEPTH; i++) rq.push_back((m_wptr + i) % DEPTH);
                    else for (int i = 0; i < m_wptr; i++) rq.push_back(i);
                end
            end
            M_ARMED: begin
                if (trigger) begin
                    m_trig  = old_w;
                    m_rem   = int'(post_count);
                    m_state = (post_count == 0) ? M_DONE : M_POST;
                end
            end
            M_POST: begin
                if (wen) begin
                    m_rem--;
                    if (m_rem == 0) m_state = M_DONE;
                end
            end
            M_READ: begin
                if (sz == 0 || (ren && sz == 1)) m_state = M_DONE;
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        arm = 0; abort = 0; trigger = 0; sample_valid = 0; post_count = '0;
        write_rdy = 1; read_start = 0; read_rdy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic feed(input int n);
        sample_valid = 1; write_rdy = 1;
        for (int i = 0; i < n; i++) tick();
        sample_valid = 0;
    endtask

    task automatic pulse_trigger(input int pc);
        trigger = 1; post_count = AW'(pc); tick(); trigger = 0;
    endtask

    // Runs a readout from DONE, recording every issued read address.
    task automatic do_readout(input bit toggle);
        rd_addrs.delete();
        rd_last_idx = -1; rd_last_count = 0; rd_viol = 0; rd_done = 0;
        read_start = 1; tick(); read_start = 0;
        for (int c = 0; c < 100 && !rd_done; c++) begin
            if (state_o !== 3'd4) begin
                rd_done = 1;
            end else begin
                read_rdy = toggle ? ((c % 2) == 0) : 1'b1;
                #1;
                if (read_ena && !read_rdy) rd_viol++;
                if (read_ena) begin
                    rd_addrs.push_back(int'(read_addr));
                    if (read_last) begin
                        rd_last_idx = rd_addrs.size() - 1;
                        rd_last_count++;
                    end
                end
                tick();
            end
        end
        read_rdy = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1; sample_valid = 1; read_rdy = 1;
        #1;
        total++; if (write_ena !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen_during: got %b want 0", write_ena); end
        tick();
        RST = 0;
        #1;
        total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
        total++; if (trig_addr !== 4'd0) begin bad++; $display("[TB] FAIL reset_trig: got %0d want 0", trig_addr); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrapped: got %b want 0", wrapped); end
        total++; if (drops !== 8'd0) begin bad++; $display("[TB] FAIL reset_drops: got %0d want 0", drops); end
        total++; if ({write_ena, read_ena, read_last} !== 3'b000) begin bad++; $display("[TB] FAIL reset_strobes_after: got %b want 000", {write_ena, read_ena, read_last}); end
        idle_inputs();
    endtask

    task automatic test_basic_capture();
        do_reset();
        pulse_arm();
        feed(5);
        pulse_trigger(3);
        feed(3);
        total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL basic_state: got %0d want 3", state_o); end
        total++; if (trig_addr !== 4'd5) begin bad++; $display("[TB] FAIL basic_trig: got %0d want 5", trig_addr); end
        total++; if (wrapped !== 1'b0) begin bad++; $display("[TB] FAIL basic_wrapped: got %b want 0", wrapped); end
        do_readout(0);
        total++; if (rd_done !== 1'b1) begin bad++; $display("[TB] FAIL basic_read_timeout: got %b want 1", rd_done); end
        total++; if (rd_addrs.size() != 8) begin bad++; $display("[TB] FAIL basic_read_count: got %0d want 8", rd_addrs.size()); end
        for (int i = 0; i < rd_addrs.size() && i < 8; i++) begin
            total++; if (rd_addrs[i] != i) begin bad++; $display("[TB] FAIL basic_read_addr[%0d]: got %0d want %0d", i, rd_addrs[i], i); end
        end
        total++; if (rd_last_idx != 7 || rd_last_count != 1) begin bad++; $display("[TB] FAIL basic_last: got idx %0d count %0d want idx 7 count 1", rd_last_idx, rd_last_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_arm();
        feed(20);
        pulse_trigger(2);
        feed(2);
        total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL wrap_state: got %0d want 3", state_o); end
        total++; if (wrapped !== 1'b1) begin bad++; $display("[TB] FAIL wrap_wrapped: got %b want 1", wrapped); end
        total++; if (trig_addr !== 4'd4) begin bad++; $display("[TB] FAIL wrap_trig: got %0d want 4", trig_addr); end
        do_readout(0);
        total++; if (rd_addrs.size() != 16) begin bad++; $display("[TB] FAIL wrap_read_count: got %0d want 16", rd_addrs.size()); end
        for (int i = 0; i < rd_addrs.size() && i < 16; i++) begin
            total++; if (rd_addrs[i] != (6 + i) % 16) begin bad++; $display("[TB] FAIL wrap_read_addr[%0d]: got %0d want %0d", i, rd_addrs[i], (6 + i) % 16); end
        end
        total++; if (rd_last_idx != 15 || rd_last_count != 1) begin bad++; $display("[TB] FAIL wrap_last: got idx %0d count %0d want idx 15 count 1", rd_last_idx, rd_last_count); end
    endtask

    task automatic test_drops();
        int wseen;
        bit rseen;
        wseen = 0;
        do_reset();
        pulse_arm();
        sample_valid = 1; write_rdy = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (write_ena) wseen++;
            tick();
        end
        sample_valid = 0; write_rdy = 1;
        total++; if (wseen != 0) begin bad++; $display("[TB] FAIL drops_writes: got %0d want 0", wseen); end
        total++; if (drops !== 8'd255) begin bad++; $display("[TB] FAIL drops_sat: got %0d want 255", drops); end
        pulse_trigger(0);
        total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL drops_done: got %0d want 3", state_o); end
        read_rdy = 1; read_start = 1; tick(); read_start = 0;
        #1;
        rseen = read_ena;
        total++; if (state_o !== 3'd4) begin bad++; $display("[TB] FAIL empty_read_state: got %0d want 4", state_o); end
        tick();
        total++; if (state_o !== 3'd3 || rseen !== 1'b0) begin bad++; $display("[TB] FAIL empty_read_return: got state %0d read %b want 3 0", state_o, rseen); end
        read_rdy = 0;
    endtask

    task automatic test_read_backpressure();
        do_reset();
        pulse_arm();
        feed(7);
        pulse_trigger(3);
        feed(3);
        do_readout(1);
        total++; if (rd_done !== 1'b1) begin bad++; $display("[TB] FAIL bp_timeout: got %b want 1", rd_done); end
        total++; if (rd_viol != 0) begin bad++; $display("[TB] FAIL bp_read_without_rdy: got %0d want 0", rd_viol); end
        total++; if (rd_addrs.size() != 10) begin bad++; $display("[TB] FAIL bp_read_count: got %0d want 10", rd_addrs.size()); end
        for (int i = 0; i < rd_addrs.size() && i < 10; i++) begin
            total++; if (rd_addrs[i] != i) begin bad++; $display("[TB] FAIL bp_read_addr[%0d]: got %0d want %0d", i, rd_addrs[i], i); end
        end
        total++; if (rd_last_idx != 9) begin bad++; $display("[TB] FAIL bp_last: got %0d want 9", rd_last_idx); end
    endtask

    task automatic test_abort();
        // Starts from DONE with trig_addr=7 left by the previous scenario.
        pulse_arm();
        feed(3);
        trigger = 1; abort = 1; sample_valid = 1; write_rdy = 1; post_count = 4'd2;
        #1;
        total++; if (write_ena !== 1'b1 || write_addr !== 4'd3) begin bad++; $display("[TB] FAIL abort_write: got %b@%0d want 1@3", write_ena, write_addr); end
        tick();
        idle_inputs();
        #1;
        total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL abort_state: got %0d want 0", state_o); end
        total++; if (trig_addr !== 4'd7) begin bad++; $display("[TB] FAIL abort_trig: got %0d want 7", trig_addr); end

        pulse_arm();
        feed(17);
        sample_valid = 1; write_rdy = 0; tick();
        sample_valid = 0; write_rdy = 1;
        pulse_trigger(5);
        feed(1);
        total++; if (state_o !== 3'd2 || wrapped !== 1'b1 || drops !== 8'd1 || trig_addr !== 4'd1) begin
            bad++; $display("[TB] FAIL post_precond: got st %0d wr %b dr %0d tr %0d want 2 1 1 1", state_o, wrapped, drops, trig_addr);
        end
        RST = 1; sample_valid = 1;
        #1;
        total++; if (write_ena !== 1'b0) begin bad++; $display("[TB] FAIL rst_post_wen: got %b want 0", write_ena); end
        tick();
        RST = 0;
        #1;
        total++; if (state_o !== 3'd0 || trig_addr !== 4'd0 || wrapped !== 1'b0 || drops !== 8'd0) begin
            bad++; $display("[TB] FAIL rst_post_values: got st %0d tr %0d wr %b dr %0d want 0 0 0 0", state_o, trig_addr, wrapped, drops);
        end
        total++; if (write_ena !== 1'b0) begin bad++; $display("[TB] FAIL rst_post_wen_after: got %b want 0", write_ena); end
        idle_inputs();
    endtask

    task automatic test_post_zero();
        int wseen;
        wseen = 0;
        do_reset();
        pulse_arm();
        feed(4);
        trigger = 1; post_count = 4'd0; sample_valid = 1; tick(); trigger = 0;
        total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL pz_state: got %0d want 3", state_o); end
        total++; if (trig_addr !== 4'd4) begin bad++; $display("[TB] FAIL pz_trig: got %0d want 4", trig_addr); end
        for (int i = 0; i < 5; i++) begin
            #1;
            if (write_ena) wseen++;
            tick();
        end
        sample_valid = 0;
        total++; if (wseen != 0) begin bad++; $display("[TB] FAIL pz_no_writes: got %0d want 0", wseen); end
        do_readout(0);
        total++; if (rd_addrs.size() != 5) begin bad++; $display("[TB] FAIL pz_read_count: got %0d want 5", rd_addrs.size()); end
    endtask

    task automatic test_random();
        bit e_wen;
        bit e_ren;
        do_reset();
        for (int c = 0; c < 3000 && bad < 50; c++) begin
            RST          = ($urandom_range(0, 199) == 0);
            abort        = ($urandom_range(0, 59) == 0);
            arm          = ($urandom_range(0, 7) == 0);
            trigger      = ($urandom_range(0, 9) == 0);
            sample_valid = $urandom_range(0, 1) == 1;
            write_rdy    = ($urandom_range(0, 3) != 0);
            post_count   = AW'($urandom_range(0, 6));
            read_start   = ($urandom_range(0, 5) == 0);
            read_rdy     = $urandom_range(0, 1) == 1;
            #1;
            e_wen = exp_wen();
            e_ren = exp_ren();
            total++; if (write_ena !== e_wen) begin bad++; $display("[TB] FAIL rnd_wen c=%0d: got %b want %b", c, write_ena, e_wen); end
            total++; if (write_addr !== (e_wen ? AW'(m_wptr) : AW'(0))) begin bad++; $display("[TB] FAIL rnd_waddr c=%0d: got %0d want %0d", c, write_addr, e_wen ? m_wptr : 0); end
            total++; if (read_ena !== e_ren) begin bad++; $display("[TB] FAIL rnd_ren c=%0d: got %b want %b", c, read_ena, e_ren); end
            total++; if (read_addr !== (e_ren ? AW'(rq[0]) : AW'(0))) begin bad++; $display("[TB] FAIL rnd_raddr c=%0d: got %0d want %0d", c, read_addr, e_ren ? rq[0] : 0); end
            total++; if (read_last !== (e_ren && rq.size() == 1)) begin bad++; $display("[TB] FAIL rnd_last c=%0d: got %b", c, read_last); end
            total++; if (state_o !== 3'(m_state)) begin bad++; $display("[TB] FAIL rnd_state c=%0d: got %0d want %0d", c, state_o, m_state); end
            total++; if (trig_addr !== AW'(m_trig)) begin bad++; $display("[TB] FAIL rnd_trig c=%0d: got %0d want %0d", c, trig_addr, m_trig); end
            total++; if (wrapped !== m_wrapped) begin bad++; $display("[TB] FAIL rnd_wrapped c=%0d: got %b want %b", c, wrapped, m_wrapped); end
            total++; if (drops !== 8'(m_drops)) begin bad++; $display("[TB] FAIL rnd_drops c=%0d: got %0d want %0d", c, drops, m_drops); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m_state = M_IDLE; m_wptr = 0; m_rem = 0; m_trig = 0; m_drops = 0; m_wrapped = 0;
        test_reset();
        test_basic_capture();
        test_wrap();
        test_drops();
        test_read_backpressure();
        test_abort();
        test_post_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
